demux_dispatch_ctrl: RTL and testbench
======================================

# demux_dispatch_ctrl

Round-robin dispatcher that sequences a `demux_1to4` and shares one input stream between four downstream lanes. It accepts words over a valid/ready handshake and holds each word in a one-entry holding register. It selects a target lane among the enabled lanes, then drives the demux select and enable so that exactly one lane sees a valid strobe. It sits between a single producer and four consumers (for example, per-lane processing units).

## Interface
- `DW`, 8, data word width
- `SKIP_BUSY`, 0, 0 = strict round-robin (wait on the target lane); 1 = skip enabled lanes whose `out_ready` is low
- `clk` input 1 — single clock, rising edge
- `rst` input 1 — reset, synchronous, active-high
- `in_valid` input 1 — producer offers `in_data`
- `in_ready` output 1 — holding register can accept this cycle
- `in_data` input DW — input word
- `lane_en` input 4 — per-lane enable mask; disabled lanes are never targeted
- `out_valid` output 4 — one-hot (or zero) valid strobe per lane
- `out_ready` input 4 — per-lane consumer ready
- `out_data` output DW — held word, broadcast to all lanes
- `cur_lane` output 2 — current target lane index; meaningful only when `|out_valid`
- `xfer_cnt` output 16 — count of completed lane transfers

## Operation
- State: `EMPTY` (hold_valid=0) and `FULL` (hold_valid=1), plus round-robin pointer `ptr[1:0]`.
- Target selection (combinational, each cycle): scan lanes `ptr`, `ptr+1`, `ptr+2`, `ptr+3` (mod 4).
  - `SKIP_BUSY=0`: the target is the first lane with `lane_en` set.
  - `SKIP_BUSY=1`: the target is the first lane with `lane_en & out_ready` set.
  - If no lane qualifies, there is no target.
- `out_valid[target]=1` only when in `FULL` and a target exists; all other bits are 0.
- Lane transfer: `out_valid[t] & out_ready[t]`. On transfer: `ptr <= t+1` (wraps 3→0) and `xfer_cnt++` (wraps 0xFFFF→0).
- `in_ready = ~hold_valid | lane_transfer`. This gives pass-through, so a new word can be accepted in the same cycle the held word leaves.
- Input accept (`in_valid & in_ready`): load `in_data` and set hold_valid=1.
- Transfer without accept: go to `EMPTY`.
- Transfer with accept: stay `FULL` with the new word.
- Valid-strobe steering uses the demux: `D=1`, `S=target`, `En=hold_valid & target_exists`, `Y=out_valid`.
- `lane_en` all zero while `FULL`:
  - The word is held indefinitely and `in_ready=0`.
  - Nothing is dropped.
- `lane_en` changing while `FULL`: the target is re-evaluated the next cycle. `out_valid` may move to another lane; the word is still delivered exactly once.
- `SKIP_BUSY=1`: `out_valid` may move between lanes as the ready inputs change. Consumers must treat valid as an offer and must not wait on valid before raising ready.
- `SKIP_BUSY=0`: while `lane_en` is stable, `out_valid` stays on one lane until that lane transfers.

## Timing
- Reset (`rst` high at a rising edge) sets:
  - hold_valid=0, `ptr=0`, `xfer_cnt=0`
  - `out_valid=0`, `cur_lane=0`, `in_ready=1` after reset releases
- `in_ready` is forced to 0 while `rst` is high.
- Reset in mid-operation discards the held word without a transfer.
- Latency: a word accepted at edge N is presented on `out_valid` during cycle N+1 (registered data, combinational strobe).
- Throughput: 1 word/cycle sustained when the target lanes are ready every cycle.
- The `out_data`, `out_valid`, `cur_lane` and `in_ready` paths are combinational from state, `lane_en` and `out_ready`. There is no combinational path from `in_valid` to any output.
- `xfer_cnt` updates at the edge that completes the transfer.

## Structure
- Shared package `demux_pkg` holds:
  - `NUM_LANES=4`
  - `lane_idx_t` (2-bit)
  - `lane_mask_t` (4-bit)
  - state enum `{EMPTY, FULL}`
- The round-robin priority scan is a natural sub-module: `rr_lane_pick` (inputs: mask, ptr; outputs: idx, found).
- Valid steering instantiates the existing `demux_1to4`.

## Test plan
- Reset, `lane_en=4'hF`, all ready, push 0x11, 0x22, 0x33, 0x44, 0x55 back-to-back → lanes 0, 1, 2, 3, 0 in order, one per cycle from cycle 1; `xfer_cnt=5`; `in_ready` stays 1.
- `SKIP_BUSY=0`, `out_ready=4'b1101`, push 0xA0, 0xA1, 0xA2 → 0xA0 goes to lane 0. 0xA1 is held on lane 1 (`in_ready=0`) until `out_ready[1]` rises 3 cycles later. 0xA2 then goes to lane 2.
- `SKIP_BUSY=1`, same stimulus → 0xA0 goes to lane 0, 0xA1 to lane 2, 0xA2 to lane 3, with no stall.
- `lane_en=4'b0000` while FULL for 10 cycles → `out_valid=0` and `in_ready=0` throughout. Setting `lane_en=4'b0100` → the word is delivered on lane 2, then `ptr=3`.
- Assert `rst` for 1 cycle while FULL with `out_ready=0` → no transfer; next cycle `out_valid=0`, `xfer_cnt=0`, `ptr=0`, `in_ready=1`.
- Preload `xfer_cnt` to 0xFFFF with 65535 transfers (or a forced state), then one more transfer → `xfer_cnt=0x0000`; `ptr` wraps 3→0 on a lane-3 transfer.

Source files
------------

// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_pkg
// Description : Shared types and constants for the four-lane dispatcher
//               (lane index/mask types, holding-register state encoding).
// Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

    localparam int NUM_LANES = 4;

    typedef logic [1:0]           lane_idx_t;
    typedef logic [NUM_LANES-1:0] lane_mask_t;

    // Holding-register occupancy: EMPTY means hold_valid=0, FULL means 1
    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } hold_state_t;

    // Next lane in round-robin order; the 2-bit add wraps 3 -> 0 naturally
    function automatic lane_idx_t lane_next(input lane_idx_t idx);
        return idx + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux_1to4.sv
`default_nettype none
// ============================================================================
// Module      : demux_1to4
// Description : One-bit 1-to-4 demultiplexer with enable. Output y[s]
//               follows d when en is high; all other outputs are low.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_1to4
    import demux_pkg::*;
(
    input  logic       d,
    input  lane_idx_t  s,
    input  logic       en,
    output lane_mask_t y
);

    // One decoder term per output lane
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign y[i] = en & d & (s == lane_idx_t'(i));
    end

endmodule
`default_nettype wire

// File: rtl/demux_dispatch_ctrl_rr_lane_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_lane_pick
// Description : Round-robin priority scan. Starting at ptr and moving
//               upward (mod 4), returns the first lane whose mask bit is set.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_lane_pick
    import demux_pkg::*;
(
    input  lane_mask_t mask,
    input  lane_idx_t  ptr,
    output lane_idx_t  idx,
    output logic       found
);

    lane_idx_t w_cand;

    // Scan from the farthest offset down so the closest qualifying lane wins
    always_comb begin
        idx    = '0;
        found  = 1'b0;
        w_cand = '0;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            w_cand = ptr + lane_idx_t'(k);
            if (mask[w_cand]) begin
                idx   = w_cand;
                found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/demux_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : demux_dispatch_ctrl
// Description : Round-robin dispatcher sharing one valid/ready input stream
//               between four lanes through a one-entry holding register.
//               The held word is broadcast; a demux steers the single valid
//               strobe to the selected lane.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_dispatch_ctrl
    import demux_pkg::*;
#(
    parameter int DW        = 8,
    parameter int SKIP_BUSY = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  lane_mask_t    lane_en,
    output lane_mask_t    out_valid,
    input  lane_mask_t    out_ready,
    output logic [DW-1:0] out_data,
    output lane_idx_t     cur_lane,
    output logic [15:0]   xfer_cnt
);

    hold_state_t   r_state;
    lane_idx_t     r_ptr;
    logic [DW-1:0] r_data;
    logic [15:0]   r_xfer_cnt;

    lane_mask_t    w_pick_mask;
    lane_idx_t     w_target;
    logic          w_found;
    logic          w_hold_valid;
    lane_mask_t    w_strobe;
    logic          w_lane_xfer;
    logic          w_accept;

    // Qualifying-lane mask: strict mode waits on the enabled target,
    // skip mode only considers lanes that are ready right now
    if (SKIP_BUSY != 0) begin : g_skip_busy
        assign w_pick_mask = lane_en & out_ready;
    end else begin : g_strict_rr
        assign w_pick_mask = lane_en;
    end

    rr_lane_pick u_pick (
        .mask  (w_pick_mask),
        .ptr   (r_ptr),
        .idx   (w_target),
        .found (w_found)
    );

    assign w_hold_valid = (r_state == FULL);

    demux_1to4 u_demux (
        .d  (1'b1),
        .s  (w_target),
        .en (w_hold_valid & w_found),
        .y  (w_strobe)
    );

    // A lane transfer frees the holding register for a same-cycle accept
    assign w_lane_xfer = |(w_strobe & out_ready);
    assign in_ready    = ~rst & (~w_hold_valid | w_lane_xfer);
    assign w_accept    = in_valid & in_ready;

    assign out_valid = w_strobe;
    assign out_data  = r_data;
    assign cur_lane  = w_target;
    assign xfer_cnt  = r_xfer_cnt;

    // Holding-register state, round-robin pointer and transfer counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= EMPTY;
            r_ptr      <= '0;
            r_data     <= '0;
            r_xfer_cnt <= '0;
        end else begin
            if (w_lane_xfer) begin
                r_ptr      <= lane_next(w_target);
                r_xfer_cnt <= r_xfer_cnt + 16'd1;
            end
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_data  <= in_data;
                        r_state <= FULL;
                    end
                end
                FULL: begin
                    if (w_accept) begin
                        r_data  <= in_data;
                        r_state <= FULL;
                    end else if (w_lane_xfer) begin
                        r_state <= EMPTY;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_demux_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_dispatch_ctrl
// Description : Scoreboard bench for demux_dispatch_ctrl. Two instances:
//               strict round-robin (s_*) and skip-busy (k_*).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_dispatch_ctrl;
    import demux_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Strict instance
    logic        s_rst, s_in_valid, s_in_ready;
    logic [7:0]  s_in_data, s_out_data;
    lane_mask_t  s_lane_en, s_out_valid, s_out_ready;
    lane_idx_t   s_cur_lane;
    logic [15:0] s_xfer_cnt;

    // Skip-busy instance
    logic        k_rst, k_in_valid, k_in_ready;
    logic [7:0]  k_in_data, k_out_data;
    lane_mask_t  k_lane_en, k_out_valid, k_out_ready;
    lane_idx_t   k_cur_lane;
    logic [15:0] k_xfer_cnt;

    demux_dispatch_ctrl #(.DW(8), .SKIP_BUSY(0)) u_dut_strict (
        .clk(clk), .rst(s_rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .lane_en(s_lane_en), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .out_data(s_out_data), .cur_lane(s_cur_lane),
        .xfer_cnt(s_xfer_cnt)
    );

    demux_dispatch_ctrl #(.DW(8), .SKIP_BUSY(1)) u_dut_skip (
        .clk(clk), .rst(k_rst), .in_valid(k_in_valid), .in_ready(k_in_ready),
        .in_data(k_in_data), .lane_en(k_lane_en), .out_valid(k_out_valid),
        .out_ready(k_out_ready), .out_data(k_out_data), .cur_lane(k_cur_lane),
        .xfer_cnt(k_xfer_cnt)
    );

    typedef struct packed {
        logic [1:0] lane;
        logic [7:0] data;
    } exp_t;

    exp_t q_s[$];
    exp_t q_k[$];
    exp_t mon_s_e, mon_k_e;
    lane_mask_t mon_s_tx, mon_k_tx;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor, strict instance
    always @(negedge clk) begin
        if (!s_rst) begin
            mon_s_tx = s_out_valid & s_out_ready;
            if (s_out_valid != '0)
                check("strict onehot", 32'($onehot(s_out_valid)), 32'd1);
            if (mon_s_tx != '0) begin
                if (q_s.size() == 0) begin
                    check("strict unexpected transfer", 32'(mon_s_tx), 32'd0);
                end else begin
                    mon_s_e = q_s.pop_front();
                    check("strict lane", 32'(s_cur_lane), 32'(mon_s_e.lane));
                    check("strict strobe", 32'(mon_s_tx), 32'd1 << mon_s_e.lane);
                    check("strict data", 32'(s_out_data), 32'(mon_s_e.data));
                end
            end
        end
    end

    // Scoreboard monitor, skip-busy instance
    always @(negedge clk) begin
        if (!k_rst) begin
            mon_k_tx = k_out_valid & k_out_ready;
            if (k_out_valid != '0)
                check("skip onehot", 32'($onehot(k_out_valid)), 32'd1);
            if (mon_k_tx != '0) begin
                if (q_k.size() == 0) begin
                    check("skip unexpected transfer", 32'(mon_k_tx), 32'd0);
                end else begin
                    mon_k_e = q_k.pop_front();
                    check("skip lane", 32'(k_cur_lane), 32'(mon_k_e.lane));
                    check("skip strobe", 32'(mon_k_tx), 32'd1 << mon_k_e.lane);
                    check("skip data", 32'(k_out_data), 32'(mon_k_e.data));
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Offer one word; optionally queue its expected delivery lane
    task automatic push_s(input logic [7:0] d, input int lane, input bit exp_out, output int stalls);
        exp_t e;
        e.lane = lane[1:0];
        e.data = d;
        if (exp_out) q_s.push_back(e);
        s_in_valid = 1'b1;
        s_in_data  = d;
        stalls     = 0;
        @(negedge clk);
        while (!s_in_ready && stalls < 100) begin
            stalls++;
            @(negedge clk);
        end
        check("strict push accepted", 32'(s_in_ready), 32'd1);
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
    endtask

    task automatic push_k(input logic [7:0] d, input int lane, output int stalls);
        exp_t e;
        e.lane = lane[1:0];
        e.data = d;
        q_k.push_back(e);
        k_in_valid = 1'b1;
        k_in_data  = d;
        stalls     = 0;
        @(negedge clk);
        while (!k_in_ready && stalls < 100) begin
            stalls++;
            @(negedge clk);
        end
        check("skip push accepted", 32'(k_in_ready), 32'd1);
        @(posedge clk);
        #1;
        k_in_valid = 1'b0;
    endtask

    task automatic reset_s();
        s_rst = 1'b1;
        sync();
        s_rst = 1'b0;
    endtask

    // Let the last accepted word leave, ending on a negedge
    task automatic drain();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int st_sum;
        logic [7:0] d;

        s_rst = 1'b1; s_in_valid = 1'b0; s_in_data = '0;
        s_lane_en = 4'hF; s_out_ready = 4'hF;
        k_rst = 1'b1; k_in_valid = 1'b0; k_in_data = '0;
        k_lane_en = 4'hF; k_out_ready = 4'b1101;

        // ---- Reset state -------------------------------------------------
        repeat (2) sync();
        s_rst = 1'b0;
        @(negedge clk);
        check("reset in_ready", 32'(s_in_ready), 32'd1);
        check("reset out_valid", 32'(s_out_valid), 32'd0);
        check("reset cur_lane", 32'(s_cur_lane), 32'd0);
        check("reset xfer_cnt", 32'(s_xfer_cnt), 32'd0);
        sync();

        // ---- Back-to-back round robin, all ready -------------------------
        st_sum = 0;
        push_s(8'h11, 0, 1'b1, st); st_sum += st;
        push_s(8'h22, 1, 1'b1, st); st_sum += st;
        push_s(8'h33, 2, 1'b1, st); st_sum += st;
        push_s(8'h44, 3, 1'b1, st); st_sum += st;
        push_s(8'h55, 0, 1'b1, st); st_sum += st;
        check("rr stalls", 32'(st_sum), 32'd0);
        drain();
        check("rr xfer_cnt", 32'(s_xfer_cnt), 32'd5);
        check("rr queue empty", 32'(q_s.size()), 32'd0);
        sync();

        // ---- Strict mode waits on a busy target lane ---------------------
        reset_s();
        s_out_ready = 4'b1101;
        push_s(8'hA0, 0, 1'b1, st);
        push_s(8'hA1, 1, 1'b1, st);
        fork
            begin
                push_s(8'hA2, 2, 1'b1, st);
            end
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("stall in_ready", 32'(s_in_ready), 32'd0);
                    check("stall out_valid", 32'(s_out_valid), 32'b0010);
                end
                sync();
                s_out_ready = 4'hF;
            end
        join
        check("strict A2 stalls", 32'(st), 32'd3);
        drain();
        check("strict xfer_cnt", 32'(s_xfer_cnt), 32'd3);
        sync();

        // ---- Skip-busy mode routes around the busy lane ------------------
        k_rst = 1'b0;
        st_sum = 0;
        push_k(8'hA0, 0, st); st_sum += st;
        push_k(8'hA1, 2, st); st_sum += st;
        push_k(8'hA2, 3, st); st_sum += st;
        check("skip stalls", 32'(st_sum), 32'd0);
        drain();
        check("skip xfer_cnt", 32'(k_xfer_cnt), 32'd3);
        check("skip queue empty", 32'(q_k.size()), 32'd0);
        sync();

        // ---- No lanes enabled while full ---------------------------------
        reset_s();
        s_out_ready = 4'hF;
        s_lane_en   = 4'b0000;
        push_s(8'hB0, 2, 1'b1, st);
        repeat (10) begin
            @(negedge clk);
            check("noen out_valid", 32'(s_out_valid), 32'd0);
            check("noen in_ready", 32'(s_in_ready), 32'd0);
        end
        sync();
        s_lane_en = 4'b0100;
        @(negedge clk);
        check("lane2 out_valid", 32'(s_out_valid), 32'b0100);
        sync();
        s_lane_en = 4'hF;
        push_s(8'hB1, 3, 1'b1, st);
        drain();
        check("noen xfer_cnt", 32'(s_xfer_cnt), 32'd2);
        sync();

        // ---- Reset while full discards the held word ---------------------
        reset_s();
        s_out_ready = 4'b0000;
        push_s(8'hC0, 0, 1'b0, st);
        @(negedge clk);
        check("held out_valid", 32'(s_out_valid), 32'b0001);
        sync();
        s_rst = 1'b1;
        @(negedge clk);
        check("rst in_ready low", 32'(s_in_ready), 32'd0);
        sync();
        s_rst = 1'b0;
        @(negedge clk);
        check("post-rst out_valid", 32'(s_out_valid), 32'd0);
        check("post-rst xfer_cnt", 32'(s_xfer_cnt), 32'd0);
        check("post-rst in_ready", 32'(s_in_ready), 32'd1);
        sync();
        s_out_ready = 4'hF;
        push_s(8'hC1, 0, 1'b1, st);
        drain();
        check("post-rst delivered", 32'(s_xfer_cnt), 32'd1);
        sync();

        // ---- Counter and pointer wrap ------------------------------------
        reset_s();
        for (int i = 0; i < 65535; i++) begin
            d = 8'(i);
            push_s(d, i % 4, 1'b1, st);
        end
        drain();
        check("cnt at max", 32'(s_xfer_cnt), 32'hFFFF);
        sync();
        push_s(8'hEE, 3, 1'b1, st);
        drain();
        check("cnt wrap", 32'(s_xfer_cnt), 32'h0000);
        sync();
        push_s(8'hEF, 0, 1'b1, st);
        drain();
        check("cnt after wrap", 32'(s_xfer_cnt), 32'h0001);

        check("final strict queue", 32'(q_s.size()), 32'd0);
        check("final skip queue", 32'(q_k.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
